// File: rtl/ahb_read_mux_n.sv
// AHB-Lite read-data/response mux: routes the data-phase slave back to the master, with a built-in default slave and an error counter.
// Latency: zero added latency in the data phase; the slave index is captured one cycle earlier, in the address phase.
// Backpressure: a low HREADY from the selected slave (or from a default-slave ERR1 cycle) freezes the captured index.
module ahb_read_mux_n #(
  parameter int N_SLAVES  = 3,
  parameter int DATA_W    = 8,
  parameter int SEL_W     = $clog2(N_SLAVES + 1),
  parameter int ERR_CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SEL_W-1:0]             HSEL_IDX,
  input  logic [1:0]                   HTRANS,
  input  logic [N_SLAVES*DATA_W-1:0]   HRDATA_S,
  input  logic [N_SLAVES-1:0]          HREADYOUT_S,
  input  logic [N_SLAVES-1:0]          HRESP_S,
  input  logic                         err_clr,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [ERR_CNT_W-1:0]         err_count
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t              state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   act_q, act_d;
  logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;

  logic                   sel_mapped;
  logic                   addr_unmapped;
  logic                   new_err;
  logic [DATA_W-1:0]      slv_rdata;
  logic                   slv_ready;
  logic                   slv_resp;

  // An index is mapped only if it names one of the real slave ports.
  function automatic logic is_mapped(input logic [SEL_W-1:0] idx);
    logic m;
    m = 1'b0;
    for (int k = 1; k <= N_SLAVES; k++) begin
      if (idx == SEL_W'(k)) m = 1'b1;
    end
    return m;
  endfunction

  // Select the data-phase slave from the captured index.
  always_comb begin
    slv_rdata  = '0;
    slv_ready  = 1'b1;
    slv_resp   = 1'b0;
    sel_mapped = 1'b0;
    for (int k = 1; k <= N_SLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        slv_rdata  = HRDATA_S[k*DATA_W-1 -: DATA_W];
        slv_ready  = HREADYOUT_S[k-1];
        slv_resp   = HRESP_S[k-1];
        sel_mapped = 1'b1;
      end
    end
  end

  // Drive master-facing outputs: mapped slave, else the default slave; reset forces an idle OKAY.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (!rst) begin
      if (sel_mapped) begin
        HRDATA = slv_rdata;
        HREADY = slv_ready;
        HRESP  = slv_resp;
      end else begin
        unique case (state_q)
          DS_ERR1: begin
            HREADY = 1'b0;
            HRESP  = 1'b1;
          end
          DS_ERR2: begin
            HREADY = 1'b1;
            HRESP  = 1'b1;
          end
          default: begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
          end
        endcase
      end
    end
  end

  assign addr_unmapped = !is_mapped(HSEL_IDX);
  assign new_err       = HREADY && HTRANS[1] && addr_unmapped;

  // Address-phase capture, frozen while the current data phase is stalled.
  always_comb begin
    sel_d = sel_q;
    act_d = act_q;
    if (HREADY) begin
      sel_d = HSEL_IDX;
      act_d = HTRANS[1];
    end
  end

  // Default-slave next state: the two-cycle ERROR response, chained for back-to-back unmapped transfers.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DS_IDLE: begin
        // An active unmapped data phase sitting in IDLE cannot arise from a legal
        // capture; if it ever does, answer it with ERROR rather than a silent OKAY.
        if (new_err || (!sel_mapped && act_q)) state_d = DS_ERR1;
      end
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = new_err ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // Saturating error counter; a clear takes priority over an increment.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (state_q == DS_ERR2 && cnt_q != {ERR_CNT_W{1'b1}}) begin
      cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DS_IDLE;
      sel_q   <= '0;
      act_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err_count = cnt_q;

endmodule

// File: tb/tb_ahb_read_mux_n.sv
// Directed bench for ahb_read_mux_n (3 slaves, 8-bit data, 2-bit error counter).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Expected values are hand-computed per cycle.
module tb_ahb_read_mux_n;

  localparam int N_SLAVES  = 3;
  localparam int DATA_W    = 8;
  localparam int SEL_W     = 2;
  localparam int ERR_CNT_W = 2;

  logic                       clk;
  logic                       rst;
  logic [SEL_W-1:0]           HSEL_IDX;
  logic [1:0]                 HTRANS;
  logic [N_SLAVES*DATA_W-1:0] HRDATA_S;
  logic [N_SLAVES-1:0]        HREADYOUT_S;
  logic [N_SLAVES-1:0]        HRESP_S;
  logic                       err_clr;
  logic [DATA_W-1:0]          HRDATA;
  logic                       HREADY;
  logic                       HRESP;
  logic [ERR_CNT_W-1:0]       err_count;

  int tests = 0;
  int fails = 0;

  ahb_read_mux_n #(
    .N_SLAVES(N_SLAVES), .DATA_W(DATA_W), .SEL_W(SEL_W), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .HSEL_IDX(HSEL_IDX), .HTRANS(HTRANS),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .err_clr(err_clr), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic [1:0]  hsel;
    logic [1:0]  htrans;
    logic [23:0] rdata_s;
    logic [2:0]  rdy_s;
    logic [2:0]  resp_s;
    logic        clr;
    logic [7:0]  exp_d;
    logic        exp_rdy;
    logic        exp_rsp;
    logic [1:0]  exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] d, input logic r, input logic s, input logic [1:0] c);
    logic [11:0] act, exp;
    act = {HRDATA, HREADY, HRESP, err_count};
    exp = {d, r, s, c};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {HRDATA,HREADY,HRESP,cnt}=%h/%b/%b/%0d expected %h/%b/%b/%0d",
               nm, act[11:4], act[3], act[2], act[1:0], d, r, s, c);
    end
  endtask

  int exp_cnt;

  initial begin
    rst = 1'b1; HSEL_IDX = '0; HTRANS = 2'b00; HRDATA_S = 24'h33A511;
    HREADYOUT_S = 3'b111; HRESP_S = 3'b000; err_clr = 1'b0;

    //            rst hsel htrans data       rdy     resp    clr   expD   rdy   rsp   cnt
    vq.push_back('{1'b1, 2'd0, 2'b00, 24'h33A511, 3'b111, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0});
    vq.push_back('{1'b1, 2'd0, 2'b00, 24'h33A511, 3'b111, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0});
    vq.push_back('{1'b0, 2'd2, 2'b10, 24'h33A511, 3'b111, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0});
    vq.push_back('{1'b0, 2'd0, 2'b00, 24'h33A511, 3'b111, 3'b000, 1'b0, 8'hA5, 1'b1, 1'b0, 2'd0});
    vq.push_back('{1'b0, 2'd1, 2'b10, 24'h33A511, 3'b111, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0});
    vq.push_back('{1'b0, 2'd3, 2'b10, 24'h33A511, 3'b110, 3'b000, 1'b0, 8'h11, 1'b0, 1'b0, 2'd0});
    vq.push_back('{1'b0, 2'd3, 2'b10, 24'h33A522, 3'b110, 3'b000, 1'b0, 8'h22, 1'b0, 1'b0, 2'd0});
    vq.push_back('{1'b0, 2'd3, 2'b10, 24'h33A544, 3'b110, 3'b000, 1'b0, 8'h44, 1'b0, 1'b0, 2'd0});
    vq.push_back('{1'b0, 2'd3, 2'b10, 24'h33A555, 3'b111, 3'b000, 1'b0, 8'h55, 1'b1, 1'b0, 2'd0});
    vq.push_back('{1'b0, 2'd0, 2'b10, 24'h33A555, 3'b111, 3'b100, 1'b0, 8'h33, 1'b1, 1'b1, 2'd0});
    vq.push_back('{1'b0, 2'd0, 2'b00, 24'h33A555, 3'b111, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0});
    vq.push_back('{1'b0, 2'd0, 2'b00, 24'h33A555, 3'b111, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0});
    vq.push_back('{1'b0, 2'd0, 2'b00, 24'h33A555, 3'b111, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1});
    vq.push_back('{1'b0, 2'd0, 2'b00, 24'h33A555, 3'b111, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1});

    for (int i = 0; i < vq.size(); i++) begin
      cyc();
      rst = vq[i].rst; HSEL_IDX = vq[i].hsel; HTRANS = vq[i].htrans;
      HRDATA_S = vq[i].rdata_s; HREADYOUT_S = vq[i].rdy_s; HRESP_S = vq[i].resp_s;
      err_clr = vq[i].clr;
      #1;
      chk($sformatf("vec%0d", i), vq[i].exp_d, vq[i].exp_rdy, vq[i].exp_rsp, vq[i].exp_cnt);
    end

    // Back-to-back unmapped NONSEQ: counter saturates at 3, then a clear on an ERR2 edge wins.
    cyc();
    HSEL_IDX = 2'd0; HTRANS = 2'b10; err_clr = 1'b1;
    #1;
    chk("b2b_start", 8'h00, 1'b1, 1'b0, 2'd1);
    exp_cnt = 0;
    for (int p = 0; p < 5; p++) begin
      cyc();
      err_clr = 1'b0;
      #1;
      chk($sformatf("b2b_err1_%0d", p), 8'h00, 1'b0, 1'b1, exp_cnt[1:0]);
      cyc();
      if (p == 4) begin
        HTRANS = 2'b00;
        err_clr = 1'b1;
      end
      #1;
      chk($sformatf("b2b_err2_%0d", p), 8'h00, 1'b1, 1'b1, exp_cnt[1:0]);
      exp_cnt = (p == 4) ? 0 : ((exp_cnt == 3) ? 3 : exp_cnt + 1);
    end
    cyc();
    err_clr = 1'b0;
    #1;
    chk("clr_on_err2", 8'h00, 1'b1, 1'b0, 2'd0);

    // Reset asserted while the default slave is in ERR1.
    cyc();
    HSEL_IDX = 2'd0; HTRANS = 2'b10;
    #1;
    chk("rst_pre", 8'h00, 1'b1, 1'b0, 2'd0);
    cyc();
    HTRANS = 2'b00;
    #1;
    chk("rst_in_err1", 8'h00, 1'b0, 1'b1, 2'd0);
    rst = 1'b1;
    #1;
    chk("rst_during", 8'h00, 1'b1, 1'b0, 2'd0);
    cyc();
    rst = 1'b0; HSEL_IDX = 2'd2; HTRANS = 2'b00;
    #1;
    chk("rst_after", 8'h00, 1'b1, 1'b0, 2'd0);
    cyc();
    HSEL_IDX = 2'd0;
    #1;
    chk("rst_recover", 8'hA5, 1'b1, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
